// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, synchronous imem read and code register feeding control_unit,
// with branch redirects and a halt while a program is being loaded.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  prog_load,
    output logic                  imem_rd,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [23:0]           imem_data,
    output logic [23:0]           code,
    output logic                  code_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [15:0]           issued_count
);
    typedef enum logic [1:0] {FETCH, LATCH, HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
    logic [23:0]           code_q, code_d;
    logic                  code_valid_q, code_valid_d;
    logic [15:0]           cnt_q, cnt_d;

    assign imem_rd      = state_q == FETCH && !stall && !branch_taken && !prog_load;
    assign imem_addr    = pc_q;
    assign code         = code_q;
    assign code_valid   = code_valid_q;
    assign pc_out       = pc_out_q;
    assign issued_count = cnt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_out_d     = pc_out_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        cnt_d        = cnt_q;
        if (prog_load) begin
            state_d = HALT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (branch_taken) pc_d = branch_target;
                    else if (!stall) state_d = LATCH;
                end
                LATCH: begin
                    state_d = FETCH;
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end else begin
                        code_d       = imem_data;
                        pc_out_d     = pc_q;
                        pc_d         = pc_q + 1'b1;
                        code_valid_d = 1'b1;
                        cnt_d        = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pc_out_q     <= RESET_PC;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_out_q     <= pc_out_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule
